// File: rtl/slow_mem_responder_pkg.sv
// Shared widths and state/op encodings for the slow-memory line responder.
package slow_mem_responder_pkg;
   localparam int LINE_W      = 128;
   localparam int MEM_ADDR_HI = 31;
   localparam int MEM_ADDR_LO = 4;
   localparam int COUNT_W     = 16;
   // Latency down-counter width; holds LATENCY-1 for LATENCY up to 255.
   localparam int CNT_W       = 8;

   typedef logic [LINE_W-1:0]              line_t;
   typedef logic [MEM_ADDR_HI:MEM_ADDR_LO] line_addr_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_e;

   typedef enum logic {
      OP_READ  = 1'b0,
      OP_WRITE = 1'b1
   } op_e;
endpackage

// File: rtl/slow_mem_responder_if.sv
// Cache <-> slow-memory line bus: the cache is master, the responder is slave.
interface slow_mem_responder_if;
   import slow_mem_responder_pkg::*;

   logic       mem_read;
   logic       mem_write;
   line_addr_t mem_addr;
   line_t      mem_wdata;
   line_t      mem_rdata;
   logic       mem_ready;

   modport master (
      output mem_read, mem_write, mem_addr, mem_wdata,
      input  mem_rdata, mem_ready
   );

   modport slave (
      input  mem_read, mem_write, mem_addr, mem_wdata,
      output mem_rdata, mem_ready
   );
endinterface

// File: rtl/slow_mem_responder_line_array.sv
// Line storage with a transaction write port, a backdoor write port and a
// combinational read port. Contents are deliberately not reset.
module mem_line_array
   import slow_mem_responder_pkg::*;
#(
   parameter int DEPTH_LOG2 = 8
) (
   input  logic                  clk,
   input  logic                  txn_we_i,
   input  logic [DEPTH_LOG2-1:0] txn_idx_i,
   input  line_t                 txn_wdata_i,
   input  logic                  bd_we_i,
   input  logic [DEPTH_LOG2-1:0] bd_idx_i,
   input  line_t                 bd_wdata_i,
   input  logic [DEPTH_LOG2-1:0] rd_idx_i,
   output line_t                 rd_data_o
);
   line_t lines_q [2**DEPTH_LOG2];

   logic bd_blocked;
   assign bd_blocked = txn_we_i && (bd_idx_i == txn_idx_i);

   // A transaction commit beats a backdoor preload to the same line.
   always_ff @(posedge clk) begin
      if (txn_we_i)
         lines_q[txn_idx_i] <= txn_wdata_i;
      if (bd_we_i && !bd_blocked)
         lines_q[bd_idx_i] <= bd_wdata_i;
   end

   assign rd_data_o = lines_q[rd_idx_i];
endmodule

// File: rtl/slow_mem_responder.sv
// Fixed-latency line responder: serves one 128-bit line per request, counts
// completed reads/writes and latches a sticky bus-protocol error flag.
module slow_mem_responder
   import slow_mem_responder_pkg::*;
#(
   parameter int LATENCY    = 8,
   parameter int DEPTH_LOG2 = 8,
   parameter int STAT_W     = COUNT_W
) (
   input  logic                  clk,
   input  logic                  proc_reset,
   slow_mem_responder_if.slave   bus,
   input  logic                  init_we,
   input  logic [DEPTH_LOG2-1:0] init_addr,
   input  line_t                 init_wdata,
   output logic                  proto_err,
   output logic [STAT_W-1:0]     rd_count,
   output logic [STAT_W-1:0]     wr_count
);
   localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LATENCY - 1);

   state_e                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   op_e                     op_q, op_d;
   logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
   line_t                   wdata_q, wdata_d;
   line_t                   rdata_q, rdata_d;
   logic                    ready_q, ready_d;
   logic                    perr_q, perr_d;
   logic [STAT_W-1:0]       rdcnt_q, rdcnt_d;
   logic [STAT_W-1:0]       wrcnt_q, wrcnt_d;

   logic                    txn_we;
   line_t                   arr_rdata;
   logic [DEPTH_LOG2-1:0]   req_idx;
   logic                    req_ok;

   // Address bits above the index alias onto the same line.
   assign req_idx = bus.mem_addr[DEPTH_LOG2+MEM_ADDR_LO-1:MEM_ADDR_LO];

   // While busy the master must keep presenting exactly the accepted op.
   assign req_ok = (op_q == OP_WRITE) ? (bus.mem_write && !bus.mem_read)
                                      : (bus.mem_read && !bus.mem_write);

   mem_line_array #(
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_lines (
      .clk         (clk),
      .txn_we_i    (txn_we && !proc_reset),
      .txn_idx_i   (idx_q),
      .txn_wdata_i (wdata_q),
      .bd_we_i     (init_we),
      .bd_idx_i    (init_addr),
      .bd_wdata_i  (init_wdata),
      .rd_idx_i    (idx_q),
      .rd_data_o   (arr_rdata)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      idx_d   = idx_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      ready_d = 1'b0;
      perr_d  = perr_q;
      rdcnt_d = rdcnt_q;
      wrcnt_d = wrcnt_q;
      txn_we  = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.mem_read && bus.mem_write) begin
               perr_d = 1'b1;
            end else if (bus.mem_read || bus.mem_write) begin
               op_d    = bus.mem_write ? OP_WRITE : OP_READ;
               idx_d   = req_idx;
               wdata_d = bus.mem_wdata;
               cnt_d   = LAT_M1;
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (!req_ok || (req_idx != idx_q))
               perr_d = 1'b1;
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               ready_d = 1'b1;
               state_d = RESP;
               if (op_q == OP_READ) begin
                  rdata_d = arr_rdata;
                  rdcnt_d = (&rdcnt_q) ? rdcnt_q : rdcnt_q + 1'b1;
               end else begin
                  txn_we  = 1'b1;
                  wrcnt_d = (&wrcnt_q) ? wrcnt_q : wrcnt_q + 1'b1;
               end
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (proc_reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         op_q    <= OP_READ;
         idx_q   <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         ready_q <= 1'b0;
         perr_q  <= 1'b0;
         rdcnt_q <= '0;
         wrcnt_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         idx_q   <= idx_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         ready_q <= ready_d;
         perr_q  <= perr_d;
         rdcnt_q <= rdcnt_d;
         wrcnt_q <= wrcnt_d;
      end
   end

   assign bus.mem_ready = ready_q;
   assign bus.mem_rdata = rdata_q;
   assign proto_err     = perr_q;
   assign rd_count      = rdcnt_q;
   assign wr_count      = wrcnt_q;
endmodule

// File: tb/tb_slow_mem_responder.sv
// Bench for slow_mem_responder: a LATENCY=8 instance and a small LATENCY=1,
// 16-line instance with narrow statistics counters for the saturation case.
module tb_slow_mem_responder;
   import slow_mem_responder_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst = 1'b0;

   slow_mem_responder_if ifa ();
   slow_mem_responder_if ifb ();

   logic        a_we = 1'b0;
   logic [7:0]  a_ia = '0;
   line_t       a_iw = '0;
   logic        a_perr;
   logic [15:0] a_rd, a_wr;

   logic        b_we = 1'b0;
   logic [3:0]  b_ia = '0;
   line_t       b_iw = '0;
   logic        b_perr;
   logic [3:0]  b_rd, b_wr;

   slow_mem_responder #(.LATENCY(8), .DEPTH_LOG2(8)) dut_a (
      .clk(clk), .proc_reset(rst), .bus(ifa.slave),
      .init_we(a_we), .init_addr(a_ia), .init_wdata(a_iw),
      .proto_err(a_perr), .rd_count(a_rd), .wr_count(a_wr)
   );

   slow_mem_responder #(.LATENCY(1), .DEPTH_LOG2(4), .STAT_W(4)) dut_b (
      .clk(clk), .proc_reset(rst), .bus(ifb.slave),
      .init_we(b_we), .init_addr(b_ia), .init_wdata(b_iw),
      .proto_err(b_perr), .rd_count(b_rd), .wr_count(b_wr)
   );

   int    n_checks = 0;
   int    n_errs   = 0;
   line_t exp_q[$];

   localparam line_t L_A5 = {16{8'hA5}};
   localparam line_t L_5  = {4{32'h5555_0005}};
   localparam line_t L_6  = {4{32'h6666_0006}};
   localparam line_t L_7  = {4{32'h7777_0007}};
   localparam line_t L_S3 = {4{32'h5A5A_0003}};

   task automatic set_req(input bit sel, input logic rd, input logic wr,
                          input logic [27:0] addr, input line_t wd);
      if (sel) begin
         ifb.mem_read = rd; ifb.mem_write = wr; ifb.mem_addr = addr; ifb.mem_wdata = wd;
      end else begin
         ifa.mem_read = rd; ifa.mem_write = wr; ifa.mem_addr = addr; ifa.mem_wdata = wd;
      end
   endtask

   task automatic preload(input bit sel, input int idx, input line_t d);
      @(posedge clk); #1;
      if (sel) begin b_we = 1'b1; b_ia = 4'(idx); b_iw = d; end
      else     begin a_we = 1'b1; a_ia = 8'(idx); a_iw = d; end
      @(posedge clk); #1;
      a_we = 1'b0; b_we = 1'b0;
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   // Drives one request and reports edges from accept to mem_ready.
   task automatic txn(input bit sel, input bit wr, input logic [27:0] addr, input line_t wd,
                      input int chg_at, input logic [27:0] chg_addr,
                      output int lat, output line_t rd, output bit tmo);
      @(posedge clk); #1;
      set_req(sel, !wr, wr, addr, wd);
      lat = -1; rd = '0; tmo = 1'b1;
      for (int k = 1; k <= 300 && tmo; k++) begin
         @(posedge clk); #1;
         if (chg_at != 0 && k == chg_at) set_req(sel, !wr, wr, chg_addr, wd);
         if (sel ? ifb.mem_ready : ifa.mem_ready) begin
            lat = k - 1;
            rd  = sel ? ifb.mem_rdata : ifa.mem_rdata;
            tmo = 1'b0;
         end
      end
      set_req(sel, 1'b0, 1'b0, addr, wd);
   endtask

   task automatic test_reset();
      do_reset();
      n_checks += 6;
      if (ifa.mem_ready !== 1'b0) begin n_errs++; $display("FAIL reset_ready: got %b want 0", ifa.mem_ready); end
      if (ifa.mem_rdata !== '0) begin n_errs++; $display("FAIL reset_rdata: got %h want 0", ifa.mem_rdata); end
      if (a_perr !== 1'b0) begin n_errs++; $display("FAIL reset_perr: got %b want 0", a_perr); end
      if (a_rd !== 16'd0 || a_wr !== 16'd0) begin n_errs++; $display("FAIL reset_counts: got %0d/%0d want 0/0", a_rd, a_wr); end
      if (ifb.mem_ready !== 1'b0 || b_perr !== 1'b0) begin n_errs++; $display("FAIL reset_b_flags: got %b/%b want 0/0", ifb.mem_ready, b_perr); end
      if (b_rd !== 4'd0 || b_wr !== 4'd0) begin n_errs++; $display("FAIL reset_b_counts: got %0d/%0d want 0/0", b_rd, b_wr); end
   endtask

   task automatic test_read_latency();
      int lat; line_t rd; bit tmo; line_t exp;
      preload(1'b0, 3, L_A5);
      exp_q.push_back(L_A5);
      txn(1'b0, 1'b0, 28'h3, '0, 0, '0, lat, rd, tmo);
      exp = exp_q.pop_front();
      n_checks += 4;
      if (tmo || lat !== 8) begin n_errs++; $display("FAIL rd_latency: got %0d want 8", lat); end
      if (rd !== exp) begin n_errs++; $display("FAIL rd_data: got %h want %h", rd, exp); end
      @(posedge clk); #1;
      if (ifa.mem_ready !== 1'b0) begin n_errs++; $display("FAIL rd_pulse_width: ready %b want 0", ifa.mem_ready); end
      if (a_rd !== 16'd1) begin n_errs++; $display("FAIL rd_count1: got %0d want 1", a_rd); end
   endtask

   task automatic test_back_to_back();
      int lat; line_t rd; bit tmo; line_t exp;
      txn(1'b0, 1'b1, 28'h10, 128'h1234, 0, '0, lat, rd, tmo);
      n_checks += 3;
      if (tmo || lat !== 8) begin n_errs++; $display("FAIL wr_latency: got %0d want 8", lat); end
      if (rd !== L_A5) begin n_errs++; $display("FAIL wr_rdata_hold: got %h want %h", rd, L_A5); end
      if (a_wr !== 16'd1) begin n_errs++; $display("FAIL wr_count1: got %0d want 1", a_wr); end
      exp_q.push_back(128'h1234);
      txn(1'b0, 1'b0, 28'h10, '0, 0, '0, lat, rd, tmo);
      exp = exp_q.pop_front();
      n_checks += 3;
      if (tmo || lat !== 8) begin n_errs++; $display("FAIL b2b_latency: got %0d want 8", lat); end
      if (rd !== exp) begin n_errs++; $display("FAIL b2b_data: got %h want %h", rd, exp); end
      if (a_rd !== 16'd2 || a_wr !== 16'd1) begin n_errs++; $display("FAIL b2b_counts: got %0d/%0d want 2/1", a_rd, a_wr); end
   endtask

   task automatic test_both_high();
      int seen; int lat; line_t rd; bit tmo; line_t exp;
      do_reset();
      seen = 0;
      @(posedge clk); #1;
      set_req(1'b0, 1'b1, 1'b1, 28'h3, '0);
      for (int k = 0; k < 20; k++) begin
         @(posedge clk); #1;
         if (ifa.mem_ready) seen++;
      end
      set_req(1'b0, 1'b0, 1'b0, 28'h3, '0);
      n_checks += 2;
      if (seen !== 0) begin n_errs++; $display("FAIL both_no_ready: got %0d pulses want 0", seen); end
      if (a_perr !== 1'b1) begin n_errs++; $display("FAIL both_perr: got %b want 1", a_perr); end
      exp_q.push_back(L_A5);
      txn(1'b0, 1'b0, 28'h3, '0, 0, '0, lat, rd, tmo);
      exp = exp_q.pop_front();
      n_checks += 3;
      if (tmo || rd !== exp) begin n_errs++; $display("FAIL both_then_read: got %h want %h", rd, exp); end
      if (a_perr !== 1'b1) begin n_errs++; $display("FAIL both_perr_sticky: got %b want 1", a_perr); end
      do_reset();
      if (a_perr !== 1'b0) begin n_errs++; $display("FAIL both_perr_reset: got %b want 0", a_perr); end
   endtask

   task automatic test_addr_change();
      int lat; line_t rd; bit tmo; line_t exp;
      do_reset();
      preload(1'b0, 5, L_5);
      preload(1'b0, 6, L_6);
      exp_q.push_back(L_5);
      txn(1'b0, 1'b0, 28'h5, '0, 3, 28'h6, lat, rd, tmo);
      exp = exp_q.pop_front();
      n_checks += 3;
      if (tmo || lat !== 8) begin n_errs++; $display("FAIL chg_latency: got %0d want 8", lat); end
      if (rd !== exp) begin n_errs++; $display("FAIL chg_data: got %h want %h", rd, exp); end
      if (a_perr !== 1'b1) begin n_errs++; $display("FAIL chg_perr: got %b want 1", a_perr); end
   endtask

   task automatic test_reset_abort();
      int seen; int lat; line_t rd; bit tmo; line_t exp;
      do_reset();
      preload(1'b0, 7, L_7);
      @(posedge clk); #1;
      set_req(1'b0, 1'b0, 1'b1, 28'h7, {4{32'hDEAD_BEEF}});
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      set_req(1'b0, 1'b0, 1'b0, 28'h7, '0);
      seen = 0;
      @(posedge clk); #1 rst = 1'b0;
      if (ifa.mem_ready) seen++;
      for (int k = 0; k < 15; k++) begin
         @(posedge clk); #1;
         if (ifa.mem_ready) seen++;
      end
      n_checks += 2;
      if (seen !== 0) begin n_errs++; $display("FAIL abort_no_ready: got %0d pulses want 0", seen); end
      if (a_wr !== 16'd0) begin n_errs++; $display("FAIL abort_wr_count: got %0d want 0", a_wr); end
      exp_q.push_back(L_7);
      txn(1'b0, 1'b0, 28'h7, '0, 0, '0, lat, rd, tmo);
      exp = exp_q.pop_front();
      n_checks += 1;
      if (tmo || rd !== exp) begin n_errs++; $display("FAIL abort_line_kept: got %h want %h", rd, exp); end
   endtask

   task automatic test_backdoor_priority();
      int lat; line_t rd; bit tmo; line_t exp;
      @(posedge clk); #1;
      set_req(1'b0, 1'b0, 1'b1, 28'h20, {4{32'h0BAD_F00D}});
      @(posedge clk);
      repeat (7) @(posedge clk);
      #1 a_we = 1'b1; a_ia = 8'h20; a_iw = {4{32'h1111_2222}};
      @(posedge clk); #1;
      a_we = 1'b0;
      n_checks += 2;
      if (ifa.mem_ready !== 1'b1) begin n_errs++; $display("FAIL prio_ready: got %b want 1", ifa.mem_ready); end
      set_req(1'b0, 1'b0, 1'b0, 28'h20, '0);
      if (a_wr !== 16'd1) begin n_errs++; $display("FAIL prio_wr_count: got %0d want 1", a_wr); end
      exp_q.push_back({4{32'h0BAD_F00D}});
      txn(1'b0, 1'b0, 28'h20, '0, 0, '0, lat, rd, tmo);
      exp = exp_q.pop_front();
      n_checks += 1;
      if (tmo || rd !== exp) begin n_errs++; $display("FAIL prio_data: got %h want %h", rd, exp); end
   endtask

   task automatic test_alias_saturate();
      int lat; line_t rd; bit tmo; line_t exp;
      do_reset();
      preload(1'b1, 3, L_S3);
      exp_q.push_back(L_S3);
      txn(1'b1, 1'b0, 28'h13, '0, 0, '0, lat, rd, tmo);
      exp = exp_q.pop_front();
      n_checks += 3;
      if (tmo || lat !== 1) begin n_errs++; $display("FAIL alias_latency: got %0d want 1", lat); end
      if (rd !== exp) begin n_errs++; $display("FAIL alias_data: got %h want %h", rd, exp); end
      if (b_rd !== 4'd1) begin n_errs++; $display("FAIL sat_count1: got %0d want 1", b_rd); end
      for (int i = 0; i < 13; i++) txn(1'b1, 1'b0, 28'h3, '0, 0, '0, lat, rd, tmo);
      n_checks += 1;
      if (b_rd !== 4'd14) begin n_errs++; $display("FAIL sat_count14: got %0d want 14", b_rd); end
      for (int i = 0; i < 6; i++) txn(1'b1, 1'b0, 28'h3, '0, 0, '0, lat, rd, tmo);
      n_checks += 2;
      if (b_rd !== 4'hF) begin n_errs++; $display("FAIL sat_count_max: got %0d want 15", b_rd); end
      if (b_wr !== 4'd0) begin n_errs++; $display("FAIL sat_wr_count: got %0d want 0", b_wr); end
   endtask

   initial begin
      set_req(1'b0, 1'b0, 1'b0, '0, '0);
      set_req(1'b1, 1'b0, 1'b0, '0, '0);
      test_reset();
      test_read_latency();
      test_back_to_back();
      test_both_high();
      test_addr_change();
      test_reset_abort();
      test_backdoor_priority();
      test_alias_saturate();
      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end
endmodule
